branch_recovery_unit: RTL and testbench
=======================================

BRANCH_RECOVERY_UNIT -- requirements
Module: branch_recovery_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC/target width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, meaning ROB tag width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning mispredict counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_br_valid  input  1  branch-unit resolution valid.
REQ-007 SHALL have port i_br_rob_tag  input  ROB_WIDTH  ROB tag of resolved branch.
REQ-008 SHALL have port i_br_mispredict  input  1  resolution disagrees with prediction.
REQ-009 SHALL have port i_br_taken  input  1  computed outcome.
REQ-010 SHALL have port i_br_target  input  DATA_WIDTH  computed taken target.
REQ-011 SHALL have port i_br_link  input  DATA_WIDTH  branch PC+4 (fall-through).
REQ-012 SHALL have port i_rob_head  input  ROB_WIDTH  current oldest ROB tag.
REQ-013 SHALL have port i_redirect_ready  input  1  fetch accepts redirect.
REQ-014 SHALL have port o_flush  output  1  one-cycle flush pulse to ROB/RS/rename.
REQ-015 SHALL have port o_flush_tag  output  ROB_WIDTH  mispredicting branch tag; entries younger are squashed.
REQ-016 SHALL have port o_redirect_valid  output  1  redirect request to fetch.
REQ-017 SHALL have port o_redirect_pc  output  DATA_WIDTH  corrected fetch PC.
REQ-018 SHALL have port o_busy  output  1  recovery in progress; dispatch stalls.
REQ-019 SHALL have port o_mispredict_count  output  CNT_WIDTH  accepted-recovery counter.

Function
REQ-020 SHALL accept a resolution only when i_br_valid && i_br_mispredict; other resolutions are ignored.
REQ-021 SHALL capture corrected PC = i_br_taken ? i_br_target : i_br_link, plus the tag.
REQ-022 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-023 IDLE: accepted mispredict -> FLUSH next cycle; else stay.
REQ-024 FLUSH: o_flush=1 for exactly one cycle with o_flush_tag=captured tag; then -> REDIRECT.
REQ-025 REDIRECT: o_redirect_valid=1, o_redirect_pc stable until i_redirect_ready; on valid&&ready -> IDLE.
REQ-026 Latency: mispredict at cycle N -> o_flush at N+1 -> o_redirect_valid at N+2 earliest.
REQ-027 Age SHALL be (tag - i_rob_head) mod 2^ROB_WIDTH; smaller age = older; wrap-around handled by this subtraction.
REQ-028 In FLUSH or REDIRECT, a new mispredict strictly older than captured SHALL replace tag/PC and return FSM to FLUSH next cycle (re-flush); younger or equal-tag mispredicts SHALL be ignored.
REQ-029 Older mispredict coincident with valid&&ready in REDIRECT: replacement wins; FSM -> FLUSH; handshake still counts as consumed by fetch.
REQ-030 o_busy SHALL be 1 in FLUSH and REDIRECT, 0 in IDLE.
REQ-031 o_mispredict_count SHALL increment once per accepted capture (including replacements), saturating at all-ones.
REQ-032 o_flush_tag and o_redirect_pc SHALL be held registers, valid whenever state != IDLE.

Reset
REQ-033 rst asserted SHALL force IDLE, o_flush=0, o_redirect_valid=0, o_busy=0, o_flush_tag=0, o_redirect_pc=0, o_mispredict_count=0 immediately.
REQ-034 Reset mid-recovery SHALL abandon recovery with no further flush/redirect; a mispredict present on the first post-reset edge is accepted normally.

Structure
REQ-035 Shared package br_pkg SHALL hold the FSM state enum and DATA_WIDTH/ROB_WIDTH defaults.
REQ-036 Age comparison SHALL be a sub-module rob_age_compare (inputs two tags + head; output a_older_than_b).
REQ-037 All outputs SHALL be registered; no combinational path from i_br_* to any output.

Verification
REQ-038 Head=0, mispredict tag=3, taken, target=0x100 -> o_flush at N+1 tag=3; redirect_valid at N+2, pc=0x100; count=1.
REQ-039 Redirect with i_redirect_ready low 5 cycles -> valid and pc=0x100 held stable; ready high -> IDLE next cycle, busy=0.
REQ-040 Head=14, capture tag=1, then mispredict tag=15 in REDIRECT -> re-flush tag=15 (older across wrap); subsequent tag=2 ignored.
REQ-041 Not-taken mispredict, i_br_link=0x204 -> o_redirect_pc=0x204; non-mispredict valid resolution -> no flush.
REQ-042 rst asserted during FLUSH -> all outputs 0 same cycle; counter at all-ones plus another capture stays all-ones.

Source files
------------

// File: rtl/br_pkg.sv
// Shared definitions for the branch recovery unit: recovery FSM states and default widths.
package br_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ROB_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } br_state_e;

endpackage

// File: rtl/rob_age_compare.sv
// Relative age of two ROB tags, measured as distance from the current ROB head.
module rob_age_compare #(
  parameter int ROB_WIDTH = br_pkg::DEF_ROB_WIDTH
) (
  input  logic [ROB_WIDTH-1:0] tag_a_i,
  input  logic [ROB_WIDTH-1:0] tag_b_i,
  input  logic [ROB_WIDTH-1:0] head_i,
  output logic                 a_older_than_b_o
);

  logic [ROB_WIDTH-1:0] age_a;
  logic [ROB_WIDTH-1:0] age_b;

  // Modular subtraction makes tags that wrapped past the head still order correctly.
  assign age_a            = tag_a_i - head_i;
  assign age_b            = tag_b_i - head_i;
  assign a_older_than_b_o = (age_a < age_b);

endmodule

// File: rtl/branch_recovery_unit.sv
// Mispredict recovery sequencer: captures the oldest mispredicting branch, flushes, then redirects fetch.
module branch_recovery_unit
  import br_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_br_valid,
  input  logic [ROB_WIDTH-1:0]  i_br_rob_tag,
  input  logic                  i_br_mispredict,
  input  logic                  i_br_taken,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic [DATA_WIDTH-1:0] i_br_link,
  input  logic [ROB_WIDTH-1:0]  i_rob_head,
  input  logic                  i_redirect_ready,
  output logic                  o_flush,
  output logic [ROB_WIDTH-1:0]  o_flush_tag,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  br_state_e             state_q, state_d;
  logic [ROB_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept;
  logic                  new_is_older;
  logic                  capture;

  assign accept = i_br_valid && i_br_mispredict;

  rob_age_compare #(
    .ROB_WIDTH (ROB_WIDTH)
  ) u_age (
    .tag_a_i          (i_br_rob_tag),
    .tag_b_i          (tag_q),
    .head_i           (i_rob_head),
    .a_older_than_b_o (new_is_older)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A strictly older mispredict always wins, even over a redirect handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) capture = 1'b1;
      end
      FLUSH: begin
        if (accept && new_is_older) capture = 1'b1;
        else                        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (accept && new_is_older) capture = 1'b1;
        else if (i_redirect_ready)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = FLUSH;
      tag_d   = i_br_rob_tag;
      pc_d    = i_br_taken ? i_br_target : i_br_link;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_flush            = (state_q == FLUSH);
  assign o_redirect_valid   = (state_q == REDIRECT);
  assign o_busy             = (state_q != IDLE);
  assign o_flush_tag        = tag_q;
  assign o_redirect_pc      = pc_q;
  assign o_mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Self-checking bench for branch_recovery_unit: directed scenarios plus randomized traffic against an event-level model.
module tb_branch_recovery_unit;

  localparam int DW   = 32;
  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          brValid, brMisp, brTaken, redirectReady;
  logic [RW-1:0] brTag, robHead;
  logic [DW-1:0] brTarget, brLink;
  logic          flush, redirectValid, busy;
  logic [RW-1:0] flushTag;
  logic [DW-1:0] redirectPc;
  logic [CW-1:0] mispCount;

  int checks = 0;
  int errors = 0;

  // Model: a recovery is "in progress" until fetch takes the redirect; a flush is owed after every capture.
  bit            mRecovering;
  bit            mFlushPending;
  logic [RW-1:0] mTag;
  logic [DW-1:0] mPc;
  int            mCount;

  always #5 clk = ~clk;

  branch_recovery_unit #(
    .DATA_WIDTH (DW),
    .ROB_WIDTH  (RW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_br_valid         (brValid),
    .i_br_rob_tag       (brTag),
    .i_br_mispredict    (brMisp),
    .i_br_taken         (brTaken),
    .i_br_target        (brTarget),
    .i_br_link          (brLink),
    .i_rob_head         (robHead),
    .i_redirect_ready   (redirectReady),
    .o_flush            (flush),
    .o_flush_tag        (flushTag),
    .o_redirect_valid   (redirectValid),
    .o_redirect_pc      (redirectPc),
    .o_busy             (busy),
    .o_mispredict_count (mispCount)
  );

  function automatic int ageOf(input logic [RW-1:0] tag, input logic [RW-1:0] head);
    return ((int'(tag) - int'(head)) + (1 << RW)) % (1 << RW);
  endfunction

  task automatic modelReset();
    mRecovering   = 1'b0;
    mFlushPending = 1'b0;
    mTag          = '0;
    mPc           = '0;
    mCount        = 0;
  endtask

  task automatic modelCapture();
    mTag          = brTag;
    mPc           = brTaken ? brTarget : brLink;
    mRecovering   = 1'b1;
    mFlushPending = 1'b1;
    if (mCount < CMAX) mCount++;
  endtask

  task automatic modelStep();
    bit accept;
    accept = brValid && brMisp;
    if (rst) modelReset();
    else if (!mRecovering) begin
      if (accept) modelCapture();
    end else if (accept && ageOf(brTag, robHead) < ageOf(mTag, robHead)) modelCapture();
    else if (mFlushPending) mFlushPending = 1'b0;
    else if (redirectReady) mRecovering = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("flush",          64'(flush),         64'(mRecovering && mFlushPending));
    chk("redirect_valid", 64'(redirectValid), 64'(mRecovering && !mFlushPending));
    chk("busy",           64'(busy),          64'(mRecovering));
    chk("flush_tag",      64'(flushTag),      64'(mTag));
    chk("redirect_pc",    64'(redirectPc),    64'(mPc));
    chk("count",          64'(mispCount),     64'(mCount));
  endtask

  task automatic applyStimulus(input bit v, input bit m, input bit t, input int tag, input int head,
                               input logic [DW-1:0] target, input logic [DW-1:0] link, input bit rdy);
    brValid       = v;
    brMisp        = m;
    brTaken       = t;
    brTag         = RW'(tag);
    robHead       = RW'(head);
    brTarget      = target;
    brLink        = link;
    redirectReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleCycle(input int head, input bit rdy);
    applyStimulus(0, 0, 0, 0, head, 32'h0, 32'h0, rdy);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    modelReset();
    #3;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Basic taken mispredict, flush then redirect, with a stalled fetch.
    applyStimulus(1, 1, 1, 3, 0, 32'h100, 32'h44, 0);
    tick();
    chk("dir_flush_n1", 64'(flush), 64'd1);
    chk("dir_tag_n1", 64'(flushTag), 64'd3);
    idleCycle(0, 0);
    chk("dir_redir_n2", 64'(redirectValid), 64'd1);
    chk("dir_pc_n2", 64'(redirectPc), 64'h100);
    chk("dir_count_1", 64'(mispCount), 64'd1);
    for (int i = 0; i < 5; i++) idleCycle(0, 0);
    chk("dir_pc_held", 64'(redirectPc), 64'h100);
    idleCycle(0, 1);
    chk("dir_busy_done", 64'(busy), 64'd0);

    // Age across the ROB wrap: head=14 makes tag 15 older than tag 1, tag 2 younger.
    applyStimulus(1, 1, 1, 1, 14, 32'h300, 32'h304, 0);
    tick();
    idleCycle(14, 0);
    applyStimulus(1, 1, 1, 15, 14, 32'h500, 32'h504, 0);
    tick();
    chk("dir_wrap_reflush", 64'(flush), 64'd1);
    chk("dir_wrap_tag", 64'(flushTag), 64'd15);
    applyStimulus(1, 1, 1, 2, 14, 32'h600, 32'h604, 0);
    tick();
    chk("dir_young_ignored", 64'(flushTag), 64'd15);
    idleCycle(14, 1);

    // Not-taken recovery uses the link address; a correct prediction does nothing.
    applyStimulus(1, 1, 0, 5, 0, 32'h900, 32'h204, 0);
    tick();
    idleCycle(0, 0);
    chk("dir_link_pc", 64'(redirectPc), 64'h204);
    idleCycle(0, 1);
    applyStimulus(1, 0, 1, 6, 0, 32'h700, 32'h704, 1);
    tick();
    chk("dir_no_flush", 64'(flush), 64'd0);

    // Older mispredict coinciding with a redirect handshake takes priority.
    applyStimulus(1, 1, 1, 8, 0, 32'ha00, 32'ha04, 0);
    tick();
    idleCycle(0, 0);
    applyStimulus(1, 1, 1, 4, 0, 32'hb00, 32'hb04, 1);
    tick();
    chk("dir_race_flush", 64'(flush), 64'd1);
    idleCycle(0, 1);
    idleCycle(0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 60), 1'($urandom),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    DW'($urandom), DW'($urandom), ($urandom_range(0, 99) < 35));
      tick();
    end

    // Saturation: keep capturing until the counter pins at all-ones.
    for (int i = 0; i < CMAX + 3; i++) begin
      applyStimulus(1, 1, 1, i % 16, 0, 32'h1000, 32'h1004, 1);
      tick();
      idleCycle(0, 1);
      idleCycle(0, 1);
    end
    chk("dir_count_sat", 64'(mispCount), 64'(CMAX));

    // Async reset in the middle of a flush, then a mispredict on the first post-reset edge.
    applyStimulus(1, 1, 1, 7, 0, 32'h2000, 32'h2004, 0);
    tick();
    chk("dir_sat_hold", 64'(mispCount), 64'(CMAX));
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    chk("dir_rst_flush", 64'(flush), 64'd0);
    chk("dir_rst_count", 64'(mispCount), 64'd0);
    #2;
    rst = 1'b0;
    applyStimulus(1, 1, 1, 9, 0, 32'h3000, 32'h3004, 0);
    tick();
    chk("dir_post_rst_flush", 64'(flush), 64'd1);
    idleCycle(0, 0);
    idleCycle(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
